// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button pins in, conditioned press pulses and debounced levels out.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] pulse;
    logic [N_BTN-1:0] level;
    modport master (output btn, input pulse, level);
    modport slave (input btn, output pulse, level);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and one-hot press pulses for lock buttons.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    button_conditioner_if.slave btn_if
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_conditioner: invalid parameter set");
    end

    logic [N_BTN-1:0]         raw, sync1_q, sync2_q, stable_q, stable_d, level_q, pulse_q;
    logic [N_BTN-1:0]         press_req, req, pulse_d;
    logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;

    assign raw = BTN_ACTIVE_LOW ? ~btn_if.btn : btn_if.btn;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            level_q  <= '0;
            pulse_q  <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            level_q  <= stable_q;
            pulse_q  <= pulse_d;
        end
    end

    // Counter only runs while the synchronised input disagrees with stable.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) stable_d[i] = ~stable_q[i];
                else cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // level_q lags stable_q by one cycle, so this marks the 0->1 transition.
    assign press_req = stable_q & ~level_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(REP_MAX + 1);

    logic [N_BTN-1:0][HW-1:0] hold_q, hold_d, lim;
    logic [N_BTN-1:0]         rep_q, rep_d, rep_req;

    // Requests persist while the hold count sits at its limit, so a repeat lost to arbitration retries.
    always_comb begin
        lim     = '0;
        rep_req = '0;
        for (int i = 0; i < N_BTN; i++) begin
            lim[i]     = rep_q[i] ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1);
            rep_req[i] = stable_q[i] & level_q[i] & (hold_q[i] >= lim[i]);
        end
    end

    always_comb begin
        hold_d = '0;
        rep_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            hold_d[i] = (!stable_q[i] || press_req[i] || pulse_d[i]) ? '0 :
                        (hold_q[i] < lim[i]) ? hold_q[i] + HW'(1) : hold_q[i];
            rep_d[i]  = stable_q[i] & (rep_q[i] | (pulse_d[i] & level_q[i]));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign req = press_req | rep_req;
`else
    assign req = press_req;
`endif

    // Lowest set bit wins; losing requests are dropped.
    assign pulse_d = req & (~req + N_BTN'(1));

    assign btn_if.pulse = pulse_q;
    assign btn_if.level = level_q;
endmodule
